// File: rtl/axi_sram_slave.sv
// AXI-lite SRAM slave. Reads and writes use independent FSMs with programmable response latency.
// Writes are byte-strobed, and out-of-range addresses return SLVERR.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);
  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [3:0] RD_LAST     = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LAST     = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rd_state_t             rd_state, rd_next;
  logic [3:0]            rd_cnt;
  logic [ADDR_WIDTH-1:2] rd_addr, rd_sel;
  logic                  rd_enter_resp;

  wr_state_t             wr_state, wr_next;
  logic [3:0]            wr_cnt;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:2] wr_addr, cm_addr;
  logic [DATA_WIDTH-1:0] wr_data, cm_data;
  logic [3:0]            wr_strb, cm_strb;
  logic                  wr_commit, cm_oor;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

  // With zero latency the sample happens on the handshake edge itself, so bypass the latch.
  assign rd_sel        = (rd_state == R_IDLE) ? araddr[ADDR_WIDTH-1:2] : rd_addr;
  assign rd_enter_resp = (rd_next == R_RESP) && (rd_state != R_RESP);
  assign cm_addr       = aw_done ? wr_addr : awaddr[ADDR_WIDTH-1:2];
  assign cm_data       = w_done ? wr_data : wdata;
  assign cm_strb       = w_done ? wr_strb : wstrb;
  assign cm_oor        = |cm_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign wr_commit     = (wr_next == W_RESP) && (wr_state != W_RESP);

  // Read FSM next state and handshake outputs
  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = !rst;
        if (arvalid && arready) begin
          rd_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
        end else begin
          rd_next = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rd_cnt == RD_LAST) rd_next = R_RESP;
        else                   rd_next = R_WAIT;
      end
      R_RESP: begin
        rvalid = !rst;
        if (rvalid && rready) rd_next = R_IDLE;
        else                  rd_next = R_RESP;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  // Read address latch, latency counter and response sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      rd_cnt  <= 4'd0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      if (arvalid && arready) rd_addr <= araddr[ADDR_WIDTH-1:2];
      rd_cnt <= (rd_state == R_WAIT && rd_next == R_WAIT) ? rd_cnt + 4'd1 : 4'd0;
      if (rd_enter_resp) begin
        if (|rd_sel[ADDR_WIDTH-1:DEPTH_LOG2+2]) begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end else begin
          rdata <= mem[rd_sel[DEPTH_LOG2+1:2]];
          rresp <= RESP_OKAY;
        end
      end
    end
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = !rst && !aw_done;
        wready  = !rst && !w_done;
        if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
          wr_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
        end else begin
          wr_next = W_IDLE;
        end
      end
      W_WAIT: begin
        if (wr_cnt == WR_LAST) wr_next = W_RESP;
        else                   wr_next = W_WAIT;
      end
      W_RESP: begin
        bvalid = !rst;
        if (bvalid && bready) wr_next = W_IDLE;
        else                  wr_next = W_RESP;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write state register
  always_ff @(posedge clk) begin
    if (rst) wr_state <= W_IDLE;
    else     wr_state <= wr_next;
  end

  // AW/W captures, latency counter and write response
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= 4'd0;
      wr_cnt  <= 4'd0;
      bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_done <= 1'b1;
        wr_addr <= awaddr[ADDR_WIDTH-1:2];
      end else if (bvalid && bready) begin
        aw_done <= 1'b0;
      end
      if (wvalid && wready) begin
        w_done  <= 1'b1;
        wr_data <= wdata;
        wr_strb <= wstrb;
      end else if (bvalid && bready) begin
        w_done <= 1'b0;
      end
      wr_cnt <= (wr_state == W_WAIT && wr_next == W_WAIT) ? wr_cnt + 4'd1 : 4'd0;
      if (wr_commit) bresp <= cm_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Memory array: byte-strobed commit, never reset
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && !cm_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_strb[i]) mem[cm_addr[DEPTH_LOG2+1:2]][8*i +: 8] <= cm_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave. Directed scenarios and randomized traffic
// are compared against a word-array memory model.
module tb_axi_sram_slave;
  localparam int RL = 2;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [1024];
  bit          known [1024];

  always #5 clk = ~clk;

  axi_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return a[31:12] != 20'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (!is_oor(a)) begin
      idx = int'(a[11:2]);
      if (s == 4'hF) begin
        model[idx] = d;
        known[idx] = 1'b1;
      end else if (known[idx]) begin
        for (int i = 0; i < 4; i++) if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  // order: 0 = AW and W together, 1 = W one cycle before AW, 2 = AW one cycle before W
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, output logic [1:0] resp, output int lat);
    bit cap_aw, cap_w, ha, hw;
    int n;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    awvalid = (order != 1); wvalid = (order != 2);
    cap_aw = 0; cap_w = 0; n = 0;
    while (!(cap_aw && cap_w) && n < 50) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick(); n++;
      if (ha) begin cap_aw = 1; awvalid = 1'b0; end
      if (hw) begin cap_w = 1; wvalid = 1'b0; end
      if (cap_w && !cap_aw) awvalid = 1'b1;
      if (cap_aw && !cap_w) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    resp = bresp;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    bit h;
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; h = 0; n = 0;
    while (!h && n < 50) begin h = arready; tick(); n++; end
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    d = rdata; resp = rresp;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy/vld=%b bresp=%b rresp=%b rdata=%h required all zero",
               {arready, awready, wready, rvalid, bvalid}, bresp, rresp, rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset: got %b required 111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic;
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, resp, lat);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (resp !== 2'b00 || lat !== WL + 1) begin
      failures++;
      $display("FAIL basic_write: got bresp=%b lat=%0d required 00 lat=%0d", resp, lat, WL + 1);
    end
    axi_read(32'h10, d, resp, lat);
    checks++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00 || lat !== RL + 1) begin
      failures++;
      $display("FAIL basic_read: got %h/%b lat=%0d required deadbeef/00 lat=%0d", d, resp, lat, RL + 1);
    end
  endtask

  task automatic test_w_before_aw;
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(32'h10, 32'h000000AA, 4'b0001, 1, resp, lat);
    model_write(32'h10, 32'h000000AA, 4'b0001);
    checks++;
    if (resp !== 2'b00 || bvalid !== 1'b0) begin
      failures++;
      $display("FAIL w_first_bresp: got bresp=%b bvalid_after=%b required 00 0", resp, bvalid);
    end
    axi_read(32'h10, d, resp, lat);
    checks++;
    if (d !== 32'hDEADBEAA || resp !== 2'b00) begin
      failures++;
      $display("FAIL w_first_read: got %h/%b required deadbeaa/00", d, resp);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] first;
    bit h; int n;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0; h = 0; n = 0;
    while (!h && n < 50) begin h = arready; tick(); n++; end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      checks++;
      if (arready !== 1'b0) begin failures++; $display("FAIL bp_arready_wait: got %b required 0", arready); end
      tick(); n++;
    end
    first = rdata;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== first || rdata !== model[4] || arready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: got rvalid=%b rdata=%h arready=%b required 1 %h 0", rvalid, rdata, arready, model[4]);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got arready=%b rvalid=%b required 1 0", arready, rvalid);
    end
  endtask

  task automatic test_out_of_range;
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(32'h0, 32'h12345678, 4'hF, 0, resp, lat);
    model_write(32'h0, 32'h12345678, 4'hF);
    axi_write(32'h1000, 32'hCAFEF00D, 4'hF, 2, resp, lat);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL oor_bresp: got %b required 10", resp); end
    axi_read(32'h1000, d, resp, lat);
    checks++;
    if (resp !== 2'b10 || d !== 32'd0) begin
      failures++;
      $display("FAIL oor_read: got %h/%b required 00000000/10", d, resp);
    end
    axi_read(32'h0, d, resp, lat);
    checks++;
    if (d !== model[0] || resp !== 2'b00) begin
      failures++;
      $display("FAIL oor_word0: got %h/%b required %h/00", d, resp, model[0]);
    end
    axi_write(32'h10, 32'hFFFFFFFF, 4'b0000, 0, resp, lat);
    axi_read(32'h10, d, resp, lat);
    checks++;
    if (d !== model[4]) begin failures++; $display("FAIL zero_strobe: got %h required %h", d, model[4]); end
  endtask

  task automatic test_same_edge;
    logic [1:0] resp; logic [31:0] d; int lat; int n;
    axi_write(32'h40, 32'h11111111, 4'hF, 0, resp, lat);
    model_write(32'h40, 32'h11111111, 4'hF);
    araddr = 32'h40; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h40; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    checks++;
    if (rdata !== 32'h11111111 || bvalid !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_old: got rdata=%h bvalid=%b required 11111111 1", rdata, bvalid);
    end
    tick();
    model_write(32'h40, 32'h22222222, 4'hF);
    axi_read(32'h40, d, resp, lat);
    checks++;
    if (d !== 32'h22222222) begin failures++; $display("FAIL same_edge_new: got %h required 22222222", d); end
  endtask

  task automatic test_reset_inflight;
    logic [1:0] resp; logic [31:0] d; int lat; bit seen;
    axi_write(32'h80, 32'h33333333, 4'hF, 0, resp, lat);
    model_write(32'h80, 32'h33333333, 4'hF);
    araddr = 32'h80; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h80; wdata = 32'h44444444; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      failures++;
      $display("FAIL inflight_ready: got %b required 111", {arready, awready, wready});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid || bvalid) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL inflight_dropped: got response=%b required 0", seen); end
    axi_read(32'h80, d, resp, lat);
    checks++;
    if (d !== model[32]) begin failures++; $display("FAIL inflight_mem: got %h required %h", d, model[32]); end
  endtask

  task automatic test_random;
    logic [1:0] resp; logic [31:0] a, d, got; logic [3:0] s; int lat, idx;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      axi_write(32'(i * 4), d, 4'hF, $urandom_range(0, 2), resp, lat);
      model_write(32'(i * 4), d, 4'hF);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL rnd_fill: word %0d got bresp %b required 00", i, resp); end
    end
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      d = $urandom; s = 4'($urandom_range(0, 15));
      axi_write(a, d, s, $urandom_range(0, 2), resp, lat);
      model_write(a, d, s);
      checks++;
      if (resp !== (is_oor(a) ? 2'b10 : 2'b00) || lat !== WL + 1) begin
        failures++;
        $display("FAIL rnd_write: addr %h got bresp=%b lat=%0d required oor=%0d lat=%0d", a, resp, lat, is_oor(a), WL + 1);
      end
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      axi_read(a, got, resp, lat);
      idx = int'(a[11:2]);
      checks++;
      if (is_oor(a) ? (resp !== 2'b10 || got !== 32'd0) : (resp !== 2'b00 || got !== model[idx]) || lat !== RL + 1) begin
        failures++;
        $display("FAIL rnd_read: addr %h got %h/%b lat=%0d required %h/%b lat=%0d", a, got, resp, lat,
                 is_oor(a) ? 32'd0 : model[idx], is_oor(a) ? 2'b10 : 2'b00, RL + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin model[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_basic();
    test_w_before_aw();
    test_backpressure();
    test_out_of_range();
    test_same_edge();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
